// File: rtl/pcs_tx_pkg.sv
// pcs_tx_pkg: dword primitives and FSM state type shared by the PCS TX align inserter
package pcs_tx_pkg;
  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A4ABC;
  localparam logic [3:0]  ALIGN_K    = 4'b0001;
  localparam logic [31:0] SYNC_PRIM  = 32'hB5B5957C;
  localparam logic [3:0]  SYNC_K     = 4'b0001;
  typedef enum logic {ST_DATA, ST_ALIGN} pcs_tx_state_t;
endpackage

// File: rtl/pcs_tx_prim_slicer.sv
// pcs_tx_prim_slicer: selects the BYTES-wide slice and K-flags of a dword primitive by word phase
module pcs_tx_prim_slicer #(
  parameter int BYTES = 4
) (
  input  logic [31:0]        prim_i,
  input  logic [3:0]         prim_k_i,
  input  logic               phase_i,
  output logic [8*BYTES-1:0] data_o,
  output logic [BYTES-1:0]   k_o
);
  assign data_o = (8*BYTES)'(phase_i ? prim_i >> 16 : prim_i);
  assign k_o    = BYTES'(phase_i ? prim_k_i >> 2 : prim_k_i);
endmodule

// File: rtl/pcs_align_inserter.sv
// pcs_align_inserter: registered TX pass-through with SYNC idle fill and periodic ALIGN bursts.
// Optional PCS_ALIGN_MARK_EN adds o_align_mark flagging words that carry the ALIGN K28.5 byte.
module pcs_align_inserter
  import pcs_tx_pkg::*;
#(
  parameter int BYTES        = 4,
  parameter int ALIGN_PERIOD = 256,
  parameter int ALIGN_COUNT  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [8*BYTES-1:0] i_data,
  input  logic [BYTES-1:0]   i_datak,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_align_force,
  output logic [8*BYTES-1:0] o_data,
  output logic [BYTES-1:0]   o_datak
`ifdef PCS_ALIGN_MARK_EN
  ,
  output logic [BYTES-1:0]   o_align_mark
`endif
);
  localparam int WPD         = 4 / BYTES;
  localparam int GAP_WORDS   = (ALIGN_PERIOD - ALIGN_COUNT) * WPD;
  localparam int BURST_WORDS = ALIGN_COUNT * WPD;
  localparam int GW          = $clog2(GAP_WORDS - 1) + 1;
  localparam int BW          = $clog2(BURST_WORDS - 1) + 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_WORDS - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_WORDS - 1);

  pcs_tx_state_t     state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              phase_q, phase_d;
  logic              force_now, align_now, accept;
  logic [8*BYTES-1:0] sync_data, align_data;
  logic [BYTES-1:0]   sync_k, align_k;

  pcs_tx_prim_slicer #(.BYTES(BYTES)) u_sync (
    .prim_i(SYNC_PRIM), .prim_k_i(SYNC_K), .phase_i(phase_q), .data_o(sync_data), .k_o(sync_k)
  );
  pcs_tx_prim_slicer #(.BYTES(BYTES)) u_align (
    .prim_i(ALIGN_PRIM), .prim_k_i(ALIGN_K), .phase_i(phase_q), .data_o(align_data), .k_o(align_k)
  );

  // force is only honoured on a dword boundary so bursts never split a dword
  assign force_now = i_align_force && !phase_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_DATA;
      gap_q   <= '0;
      burst_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      burst_q <= burst_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    burst_d = burst_q;
    phase_d = WPD == 2 ? !phase_q : 1'b0;
    if (state_q == ST_DATA) begin
      if (force_now || gap_q == GAP_LAST) begin
        state_d = ST_ALIGN;
        gap_d   = '0;
        burst_d = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end else if (i_align_force) begin
      burst_d = (WPD == 1 || phase_q) ? '0 : burst_q + 1'b1;
    end else if (burst_q == BURST_LAST) begin
      state_d = ST_DATA;
      gap_d   = '0;
    end else begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_comb begin
    align_now = state_q == ST_ALIGN || force_now;
    o_ready   = reset_n && state_q == ST_DATA && !force_now;
    accept    = i_valid && o_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_data  <= '0;
      o_datak <= '0;
`ifdef PCS_ALIGN_MARK_EN
      o_align_mark <= '0;
`endif
    end else begin
      o_data  <= align_now ? align_data : accept ? i_data : sync_data;
      o_datak <= align_now ? align_k : accept ? i_datak : sync_k;
`ifdef PCS_ALIGN_MARK_EN
      o_align_mark <= BYTES'(align_now && !phase_q);
`endif
    end
  end
endmodule

// File: tb/tb_pcs_align_inserter.sv
// tb_pcs_align_inserter: segment-table stimulus with a scoreboard for BYTES=4 and BYTES=2 inserters
module tb_pcs_align_inserter;
  typedef struct {bit rst_n; bit valid; bit frc; int len; bit ready; bit align;} seg_t;
  typedef struct {logic [31:0] d; logic [3:0] k; logic [3:0] m;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4_n = 1'b0, valid4 = 1'b0, force4 = 1'b0, o_ready4;
  logic [31:0] data4 = '0, o_data4;
  logic [3:0]  datak4 = '0, o_datak4;
  logic        rst2_n = 1'b0, valid2 = 1'b0, force2 = 1'b0, o_ready2;
  logic [15:0] data2 = '0, o_data2;
  logic [1:0]  datak2 = '0, o_datak2;
`ifdef PCS_ALIGN_MARK_EN
  logic [3:0]  o_mark4;
  logic [1:0]  o_mark2;
`endif

  pcs_align_inserter #(.BYTES(4)) u_dut4 (
    .clk(clk), .reset_n(rst4_n), .i_data(data4), .i_datak(datak4), .i_valid(valid4),
    .o_ready(o_ready4), .i_align_force(force4), .o_data(o_data4), .o_datak(o_datak4)
`ifdef PCS_ALIGN_MARK_EN
    , .o_align_mark(o_mark4)
`endif
  );
  pcs_align_inserter #(.BYTES(2)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .i_data(data2), .i_datak(datak2), .i_valid(valid2),
    .o_ready(o_ready2), .i_align_force(force2), .o_data(o_data2), .o_datak(o_datak2)
`ifdef PCS_ALIGN_MARK_EN
    , .o_align_mark(o_mark2)
`endif
  );

  int passed = 0, total = 0;
  exp_t sb[$];
  int unsigned cnt4 = 0, cnt2 = 0;
  bit ph2 = 1'b0, last_v2 = 1'b0;
  seg_t t4[$], t2[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic step4(bit r, bit v, bit f, bit er, bit ea);
    exp_t e, g;
    @(negedge clk);
    rst4_n = r; valid4 = v; force4 = f; data4 = cnt4 * 32'h01010101 + 32'h00030507; datak4 = 4'(cnt4);
    #1 chk("ready4", 32'(o_ready4), 32'(er));
    if (!r) e = '{32'h0, 4'h0, 4'h0};
    else if (ea) e = '{32'h7B4A4ABC, 4'b0001, 4'b0001};
    else if (er && v) e = '{data4, datak4, 4'h0};
    else e = '{32'hB5B5957C, 4'b0001, 4'h0};
    sb.push_back(e);
    if (r && er && v) cnt4++;
    @(posedge clk);
    #1 g = sb.pop_front();
    chk("data4", o_data4, g.d);
    chk("datak4", 32'(o_datak4), 32'(g.k));
`ifdef PCS_ALIGN_MARK_EN
    chk("mark4", 32'(o_mark4), 32'(g.m));
`endif
  endtask

  task automatic step2(bit r, bit v, bit f, bit er, bit ea);
    exp_t e, g;
    @(negedge clk);
    rst2_n = r; valid2 = v; force2 = f; data2 = 16'(cnt2 * 7 + 1); datak2 = 2'(cnt2);
    if (r && ph2) assert (v == last_v2) else $error("valid changed inside a dword");
    last_v2 = v;
    #1 chk("ready2", 32'(o_ready2), 32'(er));
    if (!r) e = '{32'h0, 4'h0, 4'h0};
    else if (ea) e = ph2 ? '{32'h7B4A, 4'b00, 4'h0} : '{32'h4ABC, 4'b01, 4'h1};
    else if (er && v) e = '{32'(data2), 4'(datak2), 4'h0};
    else e = ph2 ? '{32'hB5B5, 4'b00, 4'h0} : '{32'h957C, 4'b01, 4'h0};
    sb.push_back(e);
    if (r && er && v) cnt2++;
    ph2 = r ? !ph2 : 1'b0;
    @(posedge clk);
    #1 g = sb.pop_front();
    chk("data2", 32'(o_data2), g.d);
    chk("datak2", 32'(o_datak2), 32'(g.k));
`ifdef PCS_ALIGN_MARK_EN
    chk("mark2", 32'(o_mark2), 32'(g.m));
`endif
  endtask

  initial begin
    t4 = '{
      '{0,0,0,2,0,0},
      '{1,1,0,254,1,0}, '{1,1,0,2,0,1}, '{1,1,0,254,1,0}, '{1,1,0,2,0,1},
      '{1,0,0,254,1,0}, '{1,0,0,2,0,1},
      '{1,1,0,100,1,0}, '{1,1,1,10,0,1}, '{1,1,0,2,0,1}, '{1,1,0,254,1,0}, '{1,1,0,2,0,1},
      '{1,0,0,253,1,0}, '{1,0,1,3,0,1}, '{1,0,0,2,0,1}, '{1,0,0,254,1,0}, '{1,0,0,2,0,1},
      '{1,0,0,254,1,0}, '{1,0,0,1,0,1}, '{0,1,0,1,0,0}, '{1,0,0,254,1,0}, '{1,0,0,2,0,1}
    };
    t2 = '{
      '{0,0,0,2,0,0},
      '{1,1,0,508,1,0}, '{1,1,0,4,0,1}, '{1,0,0,508,1,0}, '{1,0,0,4,0,1},
      '{1,1,0,101,1,0}, '{1,1,1,1,1,0}, '{1,1,1,10,0,1}, '{1,1,0,4,0,1},
      '{1,1,0,508,1,0}, '{1,1,0,4,0,1},
      '{1,1,0,508,1,0}, '{1,1,0,1,0,1}, '{0,0,0,1,0,0}, '{1,1,0,508,1,0}, '{1,1,0,4,0,1}
    };
    foreach (t4[i])
      for (int n = 0; n < t4[i].len; n++) step4(t4[i].rst_n, t4[i].valid, t4[i].frc, t4[i].ready, t4[i].align);
    foreach (t2[i])
      for (int n = 0; n < t2[i].len; n++) step2(t2[i].rst_n, t2[i].valid, t2[i].frc, t2[i].ready, t2[i].align);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
